// File: rtl/router_pkg.sv
// router_pkg: default parameters and FIFO entry layout shared by the router crossbar.
package router_pkg;
  localparam int N_IN_D = 4;
  localparam int N_OUT_D = 4;
  localparam int W_D = 32;
  localparam int DEPTH_D = 4;
  localparam int DW_D = 3;
  typedef struct packed {
    logic [DW_D-1:0] dest;
    logic [W_D-1:0]  data;
  } entry_t;
endpackage

// File: rtl/router_fifo.sv
// router_fifo: per-input FIFO; ready depends only on fullness, head only from stored entries.
module router_fifo
  import router_pkg::*;
#(
  parameter type T = entry_t,
  parameter int DEPTH = DEPTH_D
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  T     din,
  output logic full,
  output logic ne,
  output T     head
);
  localparam int AW = $clog2(DEPTH);
  T mem [DEPTH];
  logic [AW:0] wp, rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign ne = wp != rp;
  assign head = mem[rp[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) wp <= wp + 1'b1;
      if (pop && ne) rp <= rp + 1'b1;
    end
  always_ff @(posedge clk)
    if (push && !full) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/router_rr_xbar.sv
// router_rr_xbar: N_IN x N_OUT crossbar with per-input FIFOs, per-output round-robin
// arbiters and output registers; heads with out-of-range destinations are dropped and counted.
module router_rr_xbar
  import router_pkg::*;
#(
  parameter int N_IN = N_IN_D,
  parameter int N_OUT = N_OUT_D,
  parameter int W = W_D,
  parameter int DEPTH = DEPTH_D,
  parameter int DW = DW_D
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_IN-1:0]              in_valid,
  output logic [N_IN-1:0]              in_ready,
  input  logic [N_IN*W-1:0]            in_data,
  input  logic [N_IN*DW-1:0]           in_dest,
  output logic [N_OUT-1:0]             out_valid,
  input  logic [N_OUT-1:0]             out_ready,
  output logic [N_OUT*W-1:0]           out_data,
  output logic [N_OUT*$clog2(N_IN)-1:0] out_src,
  output logic [15:0]                  drop_cnt
);
  localparam int SW = $clog2(N_IN);
  typedef struct packed {
    logic [DW-1:0] dest;
    logic [W-1:0]  data;
  } ent_t;
  ent_t head [N_IN];
  logic [N_IN-1:0] ne, full, pop, drop;
  logic [N_OUT-1:0] any, free;
  logic [SW-1:0] ptr [N_OUT];
  logic [SW-1:0] gi [N_OUT];
  logic [SW-1:0] ix;
  logic [16:0] dsum;
  genvar i;
  for (i = 0; i < N_IN; i++) begin : g_in
    router_fifo #(.T(ent_t), .DEPTH(DEPTH)) u_fifo (
      .clk(clk),
      .rst_n(rst_n),
      .push(in_valid[i]),
      .pop(pop[i]),
      .din({in_dest[i*DW +: DW], in_data[i*W +: W]}),
      .full(full[i]),
      .ne(ne[i]),
      .head(head[i])
    );
    assign in_ready[i] = !full[i];
    assign drop[i] = ne[i] && (int'(head[i].dest) >= N_OUT);
  end
  assign free = ~out_valid | out_ready;
  // Scan from the highest offset down so the requester nearest the pointer wins.
  always_comb begin
    pop = drop;
    any = '0;
    ix = '0;
    for (int j = 0; j < N_OUT; j++) begin
      gi[j] = '0;
      for (int k = N_IN - 1; k >= 0; k--) begin
        ix = SW'((int'(ptr[j]) + k) % N_IN);
        if (ne[ix] && int'(head[ix].dest) == j) begin
          any[j] = 1'b1;
          gi[j] = ix;
        end
      end
      if (any[j] && free[j]) pop[gi[j]] = 1'b1;
    end
  end
  always_comb begin
    dsum = {1'b0, drop_cnt};
    for (int k = 0; k < N_IN; k++) dsum = dsum + 17'(drop[k]);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= '0;
      out_data <= '0;
      out_src <= '0;
      drop_cnt <= '0;
      for (int j = 0; j < N_OUT; j++) ptr[j] <= '0;
    end else begin
      drop_cnt <= dsum[16] ? 16'hFFFF : dsum[15:0];
      for (int j = 0; j < N_OUT; j++)
        if (free[j]) begin
          out_valid[j] <= any[j];
          if (any[j]) begin
            out_data[j*W +: W] <= head[gi[j]].data;
            out_src[j*SW +: SW] <= gi[j];
            ptr[j] <= (gi[j] == SW'(N_IN - 1)) ? '0 : gi[j] + 1'b1;
          end
        end
    end
endmodule

// File: tb/tb_router_rr_xbar.sv
// tb_router_rr_xbar: directed checks of routing, round-robin order, backpressure, drops and reset.
module tb_router_rr_xbar;
  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] in_valid, in_ready, out_valid, out_ready;
  logic [127:0] in_data, out_data;
  logic [11:0] in_dest;
  logic [7:0] out_src;
  logic [15:0] drop_cnt;
  int checks = 0;
  int failures = 0;
  int acc;
  logic rdy;

  router_rr_xbar dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_dest(in_dest),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_src(out_src),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = '0;
    in_data = '0;
    in_dest = '0;
    out_ready = '0;
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'hF);
    chk("rst_drop_cnt", 32'(drop_cnt), 32'h0);
    chk("rst_out_src", 32'(out_src), 32'h0);
    chk("rst_out_data0", out_data[31:0], 32'h0);
    #21;
    rst_n = 1'b1;
    tick();
    chk("rel_in_ready", 32'(in_ready), 32'hF);

    // single word to output 2
    out_ready = 4'hF;
    in_valid = 4'b0001;
    in_data[31:0] = 32'hA5A5_0001;
    in_dest[2:0] = 3'd2;
    tick();
    in_valid = '0;
    chk("single_early", 32'(out_valid), 32'h0);
    tick();
    chk("single_valid", 32'(out_valid), 32'b0100);
    chk("single_data", out_data[95:64], 32'hA5A5_0001);
    chk("single_src", 32'(out_src[5:4]), 32'h0);
    chk("single_other_data", out_data[31:0] | out_data[63:32] | out_data[127:96], 32'h0);
    tick();
    chk("single_clear", 32'(out_valid), 32'h0);

    // contention on output 1
    in_valid = 4'hF;
    in_dest = {4{3'd1}};
    for (int k = 0; k < 4; k++) in_data[k*32 +: 32] = 32'hC000_0000 + 32'(k * 16);
    tick();
    for (int k = 0; k < 4; k++) in_data[k*32 +: 32] = 32'hC000_0001 + 32'(k * 16);
    tick();
    in_valid = '0;
    for (int n = 0; n < 8; n++) begin
      chk($sformatf("rr_valid%0d", n), 32'(out_valid[1]), 32'h1);
      chk($sformatf("rr_src%0d", n), 32'(out_src[3:2]), 32'(n % 4));
      chk($sformatf("rr_data%0d", n), out_data[63:32], 32'hC000_0000 + 32'((n % 4) * 16 + n / 4));
      tick();
    end
    chk("rr_drained", 32'(out_valid), 32'h0);

    // backpressure on output 0 from input 2
    out_ready = 4'b1110;
    in_dest = {4{3'd0}};
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = 4'b0100;
      in_data[95:64] = 32'hB000_0000 + 32'(acc);
      rdy = in_ready[2];
      tick();
      if (rdy) acc++;
    end
    in_valid = '0;
    chk("bp_accepted", 32'(acc), 32'd5);
    chk("bp_in_ready", 32'(in_ready), 32'b1011);
    for (int c = 0; c < 2; c++) begin
      chk("bp_hold_valid", 32'(out_valid[0]), 32'h1);
      chk("bp_hold_data", out_data[31:0], 32'hB000_0000);
      chk("bp_hold_src", 32'(out_src[1:0]), 32'h2);
      tick();
    end
    out_ready = 4'hF;
    for (int n = 1; n < 5; n++) begin
      tick();
      chk($sformatf("bp_data%0d", n), out_data[31:0], 32'hB000_0000 + 32'(n));
      chk($sformatf("bp_valid%0d", n), 32'(out_valid[0]), 32'h1);
    end
    tick();
    chk("bp_drained", 32'(out_valid), 32'h0);
    chk("bp_ready_back", 32'(in_ready), 32'hF);

    // illegal destination drops
    in_dest = {4{3'd5}};
    for (int c = 0; c < 3; c++) begin
      in_valid = 4'b0010;
      tick();
      chk("drop_no_valid", 32'(out_valid), 32'h0);
    end
    in_valid = '0;
    tick();
    tick();
    chk("drop_no_valid_end", 32'(out_valid), 32'h0);
    chk("drop_cnt3", 32'(drop_cnt), 32'd3);
    in_dest = {4{3'd7}};
    for (int c = 0; c < 100; c++) begin
      in_valid = 4'hF;
      tick();
    end
    in_valid = '0;
    tick();
    tick();
    chk("drop_cnt403", 32'(drop_cnt), 32'd403);
    for (int c = 0; c < 16400; c++) begin
      in_valid = 4'hF;
      tick();
    end
    in_valid = '0;
    tick();
    tick();
    chk("drop_sat", 32'(drop_cnt), 32'hFFFF);
    chk("drop_stream_ready", 32'(in_ready), 32'hF);
    in_valid = 4'b0001;
    tick();
    in_valid = '0;
    tick();
    tick();
    chk("drop_sat_hold", 32'(drop_cnt), 32'hFFFF);
    chk("drop_sat_no_valid", 32'(out_valid), 32'h0);

    // reset with words buffered on input 3
    out_ready = '0;
    in_dest = {4{3'd3}};
    for (int c = 0; c < 4; c++) begin
      in_valid = 4'b1000;
      in_data[127:96] = 32'hD000_0000 + 32'(c);
      tick();
    end
    in_valid = '0;
    tick();
    chk("mid_valid_before", 32'(out_valid), 32'b1000);
    chk("mid_ready_before", 32'(in_ready), 32'hF);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'h0);
    chk("mid_rst_ready", 32'(in_ready), 32'hF);
    chk("mid_rst_drop", 32'(drop_cnt), 32'h0);
    #10;
    rst_n = 1'b1;
    out_ready = 4'hF;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("mid_no_stale", 32'(out_valid), 32'h0);
    end
    chk("mid_ready_after", 32'(in_ready), 32'hF);
    chk("mid_data_after", out_data[127:96], 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/router_rr_xbar.md
ROUTER_RR_XBAR -- requirements
Module: router_rr_xbar

Interface
REQ-001 Parameter: N_IN, 4, number of input channels (2..8).
REQ-002 Parameter: N_OUT, 4, number of output channels (2..8).
REQ-003 Parameter: W, 32, payload width in bits.
REQ-004 Parameter: DEPTH, 4, per-input FIFO depth (power of two, >=2).
REQ-005 Parameter: DW, 3, destination field width; shall satisfy 2**DW >= N_OUT.
REQ-006 Port: clk  in  1  single clock, all state on rising edge.
REQ-007 Port: rst_n  in  1  asynchronous active-low reset.
REQ-008 Port: in_valid  in  N_IN  per-input word valid.
REQ-009 Port: in_ready  out  N_IN  per-input accept.
REQ-010 Port: in_data  in  N_IN*W  packed payloads, input i at [i*W +: W].
REQ-011 Port: in_dest  in  N_IN*DW  packed destination index per input.
REQ-012 Port: out_valid  out  N_OUT  per-output word valid.
REQ-013 Port: out_ready  in  N_OUT  per-output sink accept.
REQ-014 Port: out_data  out  N_OUT*W  packed payloads, output j at [j*W +: W].
REQ-015 Port: out_src  out  N_OUT*$clog2(N_IN)  source input index of word on output j.
REQ-016 Port: drop_cnt  out  16  count of words with illegal destination.

Function
REQ-017 Transfer on any channel shall occur only in a cycle where valid and ready are both 1.
REQ-018 Each input shall own a FIFO of DEPTH entries holding {dest, data}; in_ready[i] shall be 1 exactly when FIFO i is not full, independent of in_valid and any output state.
REQ-019 A FIFO at full shall not accept a word even if its head pops in the same cycle; a FIFO at empty shall not forward the word being written that cycle.
REQ-020 Each output j shall have one output register; it is "free" when out_valid[j]=0 or out_ready[j]=1.
REQ-021 Each output j shall run a round-robin arbiter over FIFO heads with dest==j; when free and at least one requester exists, it shall grant the first requester at or after its pointer, pop that FIFO, load the register, and set its pointer to granted index+1 modulo N_IN.
REQ-022 Arbiter pointer shall not change in cycles with no grant.
REQ-023 Minimum latency: word accepted at edge t shall appear on out_valid/out_data after edge t+1 (i.e. visible in cycle t+2 window), with out_src set to its input index.
REQ-024 Sustained throughput: one word per output per cycle when sources and sink are never stalled.
REQ-025 Head with dest >= N_OUT shall be popped the cycle after it reaches the head, not forwarded, and increment drop_cnt by 1; drop_cnt shall saturate at 16'hFFFF.
REQ-026 A held output word (out_valid=1, out_ready=0) shall keep out_data and out_src stable until accepted.
REQ-027 Words from one input to one output shall leave in acceptance order; no word shall be duplicated or lost except per REQ-025.

Reset
REQ-028 On rst_n=0, asynchronously: all FIFOs empty, out_valid=0, out_data=0, out_src=0, all arbiter pointers=0, drop_cnt=0; in_ready shall read 1 for every input while reset is asserted and after release.
REQ-029 Reset asserted mid-transfer shall discard all buffered and held words; no partial word shall appear after release.

Structure
REQ-030 Shared package router_pkg shall hold default parameter constants and the FIFO entry struct {dest, data}.
REQ-031 Per-input FIFO shall be a sub-module router_fifo instantiated N_IN times; arbiters and output registers reside in the top module.

Verification
REQ-032 Reset then single word: in0 data 32'hA5A5_0001 dest 2 -> out_valid[2]=1 two cycles later, out_data=32'hA5A5_0001, out_src=0; other outputs stay 0.
REQ-033 Contention: inputs 0..3 each send 2 words to output 1 simultaneously, out_ready=1 -> output 1 delivers sources 0,1,2,3,0,1,2,3 on 8 consecutive cycles.
REQ-034 Backpressure: out_ready[0]=0, input 2 sends 6 words to output 0 (DEPTH=4) -> in_ready[2] drops after 5 accepted (4 FIFO + 1 register); releasing out_ready delivers all 5 in order, stable while held.
REQ-035 Illegal dest: N_OUT=4, DW=3, dest 5 sent 3 times -> no out_valid, drop_cnt=3; preload drop_cnt path to 16'hFFFF then one more -> stays 16'hFFFF.
REQ-036 Reset mid-burst: rst_n low with 3 words buffered -> out_valid=0 immediately, after release no stale word emerges and in_ready=all ones.
